// File: rtl/ppu_pkg.sv
// ppu_pkg: shared OAM entry layout, offsets, attribute bits and scan states for the sprite evaluator.
package ppu_pkg;
  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] tile;
    logic [7:0] x;
    logic [7:0] y;
  } oam_entry_t;
  localparam logic [8:0] Y_OFFSET = 9'd16;
  localparam logic [8:0] X_OFFSET = 9'd8;
  localparam int ATTR_PAL = 4;
  localparam int ATTR_XFLIP = 5;
  localparam int ATTR_YFLIP = 6;
  localparam int ATTR_PRI = 7;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
  function automatic logic [8:0] ext9(input logic [7:0] v);
    return {1'b0, v};
  endfunction
endpackage

// File: rtl/sprite_slot.sv
// sprite_slot: one line-buffer entry with its X-cover test and flipped column.
module sprite_slot
  import ppu_pkg::*;
(
  input  logic       clockgb,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_x,
  input  logic [7:0] load_tile,
  input  logic [2:0] load_row,
  input  logic       load_xflip,
  input  logic       load_pal,
  input  logic       load_pri,
  input  logic [7:0] query_x,
  output logic       covers,
  output logic [7:0] x,
  output logic [7:0] tile,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       pal,
  output logic       pri
);
  logic valid, xflip;
  logic [8:0] qx;
  always_ff @(posedge clockgb) begin
    if (reset || clear) begin
      valid <= 1'b0;
      x <= '0;
      tile <= '0;
      row <= '0;
      xflip <= 1'b0;
      pal <= 1'b0;
      pri <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      x <= load_x;
      tile <= load_tile;
      row <= load_row;
      xflip <= load_xflip;
      pal <= load_pal;
      pri <= load_pri;
    end
  end
  // The +8 offset does not touch the low three bits, so the column needs only them.
  always_comb begin
    qx = ext9(query_x) + X_OFFSET;
    covers = valid && qx >= ext9(x) && qx < ext9(x) + X_OFFSET;
    col = (query_x[2:0] - x[2:0]) ^ {3{xflip}};
  end
endmodule

// File: rtl/ppu_sprite_scan.sv
// ppu_sprite_scan: per-line OAM scan into a sprite buffer plus registered per-pixel lookup.
// Define PPU_CGB_PRIORITY_EN for OAM-index-only priority instead of DMG x-then-index.
module ppu_sprite_scan
  import ppu_pkg::*;
#(
  parameter int SPRITE_COUNT = 40,
  parameter int MAX_PER_LINE = 10,
  parameter int IDX_W = 6,
  parameter int CNT_W = 4
) (
  input  logic             clockgb,
  input  logic             reset,
  input  logic             scan_start,
  input  logic [7:0]       line_y,
  input  logic             tall,
  output logic [IDX_W-1:0] oam_index,
  input  logic [31:0]      oam_entry,
  output logic             scan_busy,
  output logic             scan_done,
  output logic [CNT_W-1:0] sprite_count,
  output logic             overflow,
  input  logic [7:0]       query_x,
  output logic             hit,
  output logic [7:0]       hit_tile,
  output logic [2:0]       hit_row,
  output logic [2:0]       hit_col,
  output logic             hit_pal,
  output logic             hit_pri
);
  scan_state_t state;
  oam_entry_t e;
  logic issue_v, data_v, tall_q, y_match, found, show, w_pal, w_pri, unused_attr;
  logic [7:0] ly, w_x, w_tile;
  logic [8:0] ly16, ey, h;
  logic [3:0] r, row;
  logic [2:0] w_row, w_col;
  logic [MAX_PER_LINE-1:0] load, cov, s_pal, s_pri;
  logic [7:0] s_x [MAX_PER_LINE];
  logic [7:0] s_tile [MAX_PER_LINE];
  logic [2:0] s_row [MAX_PER_LINE];
  logic [2:0] s_col [MAX_PER_LINE];
  assign e = oam_entry_t'(oam_entry);
  assign unused_attr = ^e.attr[3:0];
  // Low nibble of line_y+16-y equals the nibble difference; h[3:0]-1 gives 15 or 7.
  always_comb begin
    ly16 = ext9(ly) + Y_OFFSET;
    ey = ext9(e.y);
    h = tall_q ? 9'd16 : 9'd8;
    y_match = state == SCAN && data_v && ly16 >= ey && ly16 < ey + h;
    r = ly[3:0] - e.y[3:0];
    row = e.attr[ATTR_YFLIP] ? h[3:0] - 4'd1 - r : r;
  end
  for (genvar k = 0; k < MAX_PER_LINE; k++) begin : g_slot
    assign load[k] = y_match && sprite_count == CNT_W'(k);
    sprite_slot u_slot (
      .clockgb(clockgb),
      .reset(reset),
      .clear(scan_start),
      .load(load[k]),
      .load_x(e.x),
      .load_tile(tall_q ? {e.tile[7:1], row[3]} : e.tile),
      .load_row(row[2:0]),
      .load_xflip(e.attr[ATTR_XFLIP]),
      .load_pal(e.attr[ATTR_PAL]),
      .load_pri(e.attr[ATTR_PRI]),
      .query_x(query_x),
      .covers(cov[k]),
      .x(s_x[k]),
      .tile(s_tile[k]),
      .row(s_row[k]),
      .col(s_col[k]),
      .pal(s_pal[k]),
      .pri(s_pri[k])
    );
  end
  // Slots fill in OAM order, so the lowest slot is also the lowest OAM index.
  always_comb begin
    found = 1'b0;
    w_x = '0;
    w_tile = '0;
    w_row = '0;
    w_col = '0;
    w_pal = 1'b0;
    w_pri = 1'b0;
    for (int k = 0; k < MAX_PER_LINE; k++) begin
`ifdef PPU_CGB_PRIORITY_EN
      if (cov[k] && !found) begin
`else
      if (cov[k] && (!found || s_x[k] < w_x)) begin
`endif
        found = 1'b1;
        w_x = s_x[k];
        w_tile = s_tile[k];
        w_row = s_row[k];
        w_col = s_col[k];
        w_pal = s_pal[k];
        w_pri = s_pri[k];
      end
    end
    show = found && state == IDLE && !scan_start;
  end
  always_ff @(posedge clockgb) begin
    if (reset) begin
      state <= IDLE;
      oam_index <= '0;
      issue_v <= 1'b0;
      data_v <= 1'b0;
      ly <= '0;
      tall_q <= 1'b0;
      scan_busy <= 1'b0;
      scan_done <= 1'b0;
      sprite_count <= '0;
      overflow <= 1'b0;
      hit <= 1'b0;
      hit_tile <= '0;
      hit_row <= '0;
      hit_col <= '0;
      hit_pal <= 1'b0;
      hit_pri <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      hit <= show;
      hit_tile <= show ? w_tile : '0;
      hit_row <= show ? w_row : '0;
      hit_col <= show ? w_col : '0;
      hit_pal <= show && w_pal;
      hit_pri <= show && w_pri;
      if (scan_start) begin
        state <= SCAN;
        oam_index <= '0;
        issue_v <= 1'b1;
        data_v <= 1'b0;
        ly <= line_y;
        tall_q <= tall;
        scan_busy <= 1'b1;
        sprite_count <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          SCAN: begin
            data_v <= issue_v;
            if (issue_v && oam_index == IDX_W'(SPRITE_COUNT - 1)) issue_v <= 1'b0;
            else if (issue_v) oam_index <= oam_index + 1'b1;
            if (y_match && sprite_count == CNT_W'(MAX_PER_LINE)) overflow <= 1'b1;
            else if (y_match) sprite_count <= sprite_count + 1'b1;
            if (data_v && !issue_v) begin
              state <= DONE;
              scan_done <= 1'b1;
              scan_busy <= 1'b0;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ppu_sprite_scan.sv
// tb_ppu_sprite_scan: randomized scenarios checked against a list-based OAM evaluation model.
module tb_ppu_sprite_scan;
  logic clk = 1'b0;
  logic reset, scan_start, tall;
  logic [7:0] line_y, query_x;
  logic [5:0] oam_index;
  logic [31:0] oam_entry;
  logic scan_busy, scan_done, overflow, hit, hit_pal, hit_pri;
  logic [3:0] sprite_count;
  logic [7:0] hit_tile;
  logic [2:0] hit_row, hit_col;
  logic [31:0] oam [40];
  int n_cmp = 0, n_err = 0;
  int m_ly;
  bit m_tall, m_ovf;
  int kept[$];

  ppu_sprite_scan dut (
    .clockgb(clk), .reset(reset), .scan_start(scan_start), .line_y(line_y), .tall(tall),
    .oam_index(oam_index), .oam_entry(oam_entry), .scan_busy(scan_busy), .scan_done(scan_done),
    .sprite_count(sprite_count), .overflow(overflow), .query_x(query_x), .hit(hit),
    .hit_tile(hit_tile), .hit_row(hit_row), .hit_col(hit_col), .hit_pal(hit_pal), .hit_pri(hit_pri)
  );

  always #5 clk = ~clk;
  always @(posedge clk) oam_entry <= oam[oam_index];

  function automatic void model_scan();
    int h, y;
    kept.delete();
    m_ovf = 0;
    h = m_tall ? 16 : 8;
    for (int i = 0; i < 40; i++) begin
      y = oam[i][7:0];
      if (m_ly + 16 >= y && m_ly + 16 < y + h) begin
        if (kept.size() < 10) kept.push_back(i);
        else m_ovf = 1;
      end
    end
  endfunction

  function automatic logic [16:0] model_query(input int qx);
    int best, x, y, h, rr, t, col;
    logic [7:0] attr;
    best = -1;
    foreach (kept[j]) begin
      x = oam[kept[j]][15:8];
      if (qx + 8 >= x && qx + 8 < x + 8) begin
`ifdef PPU_CGB_PRIORITY_EN
        if (best < 0) best = kept[j];
`else
        if (best < 0 || x < int'(oam[best][15:8])) best = kept[j];
`endif
      end
    end
    if (best < 0) return '0;
    y = oam[best][7:0];
    x = oam[best][15:8];
    t = oam[best][23:16];
    attr = oam[best][31:24];
    h = m_tall ? 16 : 8;
    rr = m_ly + 16 - y;
    if (attr[6]) rr = h - 1 - rr;
    if (m_tall) t = (t & 254) | (rr / 8);
    col = qx + 8 - x;
    if (attr[5]) col = 7 - col;
    return {1'b1, 8'(t), 3'(rr % 8), 3'(col), attr[4], attr[7]};
  endfunction

  function automatic logic [31:0] rand_entry(input int ly);
    logic [7:0] y;
    y = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'(ly + 16 - int'($urandom_range(0, 15)));
    return {8'($urandom), 8'($urandom), 8'($urandom_range(0, 175)), y};
  endfunction

  task automatic clear_oam();
    for (int i = 0; i < 40; i++) oam[i] = 32'h0;
  endtask

  task automatic start_scan(input int ly, input bit tl, input int qx);
    @(negedge clk);
    line_y = 8'(ly);
    tall = tl;
    query_x = 8'(qx);
    scan_start = 1'b1;
    m_ly = ly;
    m_tall = tl;
    model_scan();
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  task automatic do_scan(input int ly, input bit tl, input int qx);
    int c, bad;
    start_scan(ly, tl, qx);
    c = 0;
    bad = 0;
    while (!scan_done && c < 100) begin
      if (!scan_busy || hit) bad++;
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (c != 41) begin n_err++; $display("FAIL done_latency got=%0d exp=41", c); end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL busy_window bad_cycles=%0d exp=0", bad); end
    n_cmp++;
    if ({scan_busy, sprite_count, overflow} !== {1'b0, 4'(kept.size()), m_ovf})
      begin n_err++; $display("FAIL scan_result busy/count/ovf got=%b/%0d/%b exp=0/%0d/%b", scan_busy, sprite_count, overflow, kept.size(), m_ovf); end
    @(negedge clk);
    n_cmp++;
    if (scan_done !== 1'b0) begin n_err++; $display("FAIL done_pulse got=%b exp=0", scan_done); end
  endtask

  task automatic check_query(input int qx, input string nm);
    logic [16:0] got, exp;
    query_x = 8'(qx);
    @(negedge clk);
    exp = model_query(qx);
    got = {hit, hit_tile, hit_row, hit_col, hit_pal, hit_pri};
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL %s qx=%0d got=%h exp=%h", nm, qx, got, exp); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    scan_start = 1'b1;
    line_y = 8'd0;
    tall = 1'b0;
    query_x = 8'd0;
    clear_oam();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({oam_index, scan_busy, scan_done, sprite_count, overflow, hit, hit_tile, hit_row, hit_col, hit_pal, hit_pri} !== '0)
      begin n_err++; $display("FAIL reset_outputs got busy=%b done=%b idx=%0d hit=%b exp all 0", scan_busy, scan_done, oam_index, hit); end
    reset = 1'b0;
    scan_start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (scan_busy !== 1'b0) begin n_err++; $display("FAIL reset_beats_start busy=%b exp=0", scan_busy); end
  endtask

  task automatic test_single();
    clear_oam();
    oam[0] = {8'h00, 8'h12, 8'd8, 8'd16};
    do_scan(0, 0, 3);
    check_query(3, "single_hit");
    n_cmp++;
    if ({hit, hit_tile, hit_row, hit_col} !== {1'b1, 8'h12, 3'd0, 3'd3})
      begin n_err++; $display("FAIL single_fixed got hit=%b tile=%h row=%0d col=%0d exp 1/12/0/3", hit, hit_tile, hit_row, hit_col); end
    check_query(8, "single_edge");
  endtask

  task automatic test_overflow();
    clear_oam();
    for (int i = 0; i < 12; i++) oam[i] = {8'($urandom), 8'($urandom), 8'(8 + i * 12), 8'd20};
    do_scan(4, 0, 0);
    n_cmp++;
    if ({sprite_count, overflow} !== {4'd10, 1'b1})
      begin n_err++; $display("FAIL overflow_fixed count=%0d ovf=%b exp 10/1", sprite_count, overflow); end
    for (int i = 0; i < 12; i++) check_query(i * 12 + 1, "overflow_slots");
  endtask

  task automatic test_overlap();
    clear_oam();
    oam[2] = {8'h00, 8'hA0, 8'd20, 8'd16};
    oam[5] = {8'h00, 8'hB0, 8'd16, 8'd16};
    do_scan(0, 0, 13);
    check_query(13, "overlap_model");
    n_cmp++;
`ifdef PPU_CGB_PRIORITY_EN
    if ({hit_tile, hit_col} !== {8'hA0, 3'd1}) begin n_err++; $display("FAIL overlap_fixed tile=%h col=%0d exp A0/1", hit_tile, hit_col); end
`else
    if ({hit_tile, hit_col} !== {8'hB0, 3'd5}) begin n_err++; $display("FAIL overlap_fixed tile=%h col=%0d exp B0/5", hit_tile, hit_col); end
`endif
    for (int q = 6; q < 22; q++) check_query(q, "overlap_sweep");
  endtask

  task automatic test_tall_flip();
    clear_oam();
    oam[0] = {8'h60, 8'h30, 8'd8, 8'd16};
    do_scan(3, 1, 0);
    check_query(0, "tall_flip");
    n_cmp++;
    if ({hit, hit_tile, hit_row, hit_col} !== {1'b1, 8'h31, 3'd4, 3'd7})
      begin n_err++; $display("FAIL tall_fixed got %b/%h/%0d/%0d exp 1/31/4/7", hit, hit_tile, hit_row, hit_col); end
  endtask

  task automatic test_boundaries();
    clear_oam();
    oam[0] = {8'h00, 8'h01, 8'd50, 8'd0};
    oam[1] = {8'h00, 8'h02, 8'd60, 8'd160};
    oam[2] = {8'h00, 8'h03, 8'd0, 8'd40};
    oam[3] = {8'h00, 8'h04, 8'd168, 8'd40};
    oam[4] = {8'h10, 8'h44, 8'd100, 8'd159};
    do_scan(24, 0, 0);
    for (int q = 0; q < 160; q += 3) check_query(q, "bound_x");
    do_scan(143, 0, 0);
    check_query(93, "bound_y159");
    n_cmp++;
    if ({hit, hit_tile, hit_row, hit_pal} !== {1'b1, 8'h44, 3'd0, 1'b1})
      begin n_err++; $display("FAIL bound_fixed got %b/%h/%0d/%b exp 1/44/0/1", hit, hit_tile, hit_row, hit_pal); end
    do_scan(0, 1, 0);
    check_query(50, "bound_y0");
  endtask

  task automatic test_random();
    int ly;
    for (int n = 0; n < 6; n++) begin
      ly = $urandom_range(0, 143);
      for (int i = 0; i < 40; i++) oam[i] = rand_entry(ly);
      do_scan(ly, 1'($urandom), $urandom_range(0, 159));
      for (int q = 0; q < 24; q++) check_query($urandom_range(0, 167), "random");
    end
  endtask

  task automatic test_restart();
    for (int i = 0; i < 40; i++) oam[i] = rand_entry(70);
    start_scan(20, 0, 0);
    repeat (9) @(negedge clk);
    do_scan(70, 0, 0);
    for (int q = 0; q < 16; q++) check_query($urandom_range(0, 167), "restart");
  endtask

  task automatic test_reset_mid();
    int dones;
    clear_oam();
    for (int i = 0; i < 8; i++) oam[i] = {8'h00, 8'(i), 8'(8 + i * 4), 8'd30};
    start_scan(20, 0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({scan_busy, sprite_count} !== 5'd0) begin n_err++; $display("FAIL reset_mid busy=%b count=%0d exp 0/0", scan_busy, sprite_count); end
    dones = 0;
    query_x = 8'd2;
    repeat (50) begin @(negedge clk); if (scan_done) dones++; end
    n_cmp++;
    if (dones != 0) begin n_err++; $display("FAIL reset_mid_done pulses=%0d exp=0", dones); end
    n_cmp++;
    if (hit !== 1'b0) begin n_err++; $display("FAIL reset_mid_empty hit=%b exp=0", hit); end
    do_scan(20, 0, 0);
    for (int q = 0; q < 40; q += 2) check_query(q, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_overlap();
    test_tall_flip();
    test_boundaries();
    test_random();
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ppu_sprite_scan.md
Name: ppu_sprite_scan

Overview:
- Per-scanline OAM evaluator for the PPU. Replaces the per-pixel combinational match over all OAM entries.
- During mode 2 it walks OAM one entry per cycle and latches up to MAX_PER_LINE covering sprites into a line buffer. It flags overflow past that limit.
- During mode 3 it answers per-pixel queries with the highest-priority covering sprite, resolving tile, row, column, palette and priority.
- Sits between the OAM store and the sprite tile-RAM address path.

Parameters:
- SPRITE_COUNT, 40, number of OAM entries scanned.
- MAX_PER_LINE, 10, line-buffer slots, which is the per-line sprite limit.
- IDX_W, 6, OAM index width; must satisfy 2**IDX_W >= SPRITE_COUNT.
- CNT_W, 4, slot-count width; must satisfy 2**CNT_W > MAX_PER_LINE.

Ports:
- clockgb  in  1  PPU clock
- reset  in  1  synchronous, active-high
- scan_start  in  1  one-cycle pulse at mode-2 entry
- line_y  in  8  LY, sampled on scan_start
- tall  in  1  LCDC bit 2 (8x16 mode), sampled on scan_start
- oam_index  out  IDX_W  OAM entry address
- oam_entry  in  32  {attr, tile, x, y} (y in [7:0]), valid 1 cycle after oam_index
- scan_busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse when the buffer is valid
- sprite_count  out  CNT_W  slots filled this line
- overflow  out  1  more than MAX_PER_LINE sprites matched
- query_x  in  8  screen pixel X
- hit  out  1  a sprite covers query_x
- hit_tile  out  8  tile index, adjusted for 8x16 mode
- hit_row  out  3  row within the tile, flip applied
- hit_col  out  3  column, flip applied
- hit_pal  out  1  attr bit 4
- hit_pri  out  1  attr bit 7 (behind background)

Behaviour:
- Reset values: state IDLE; every output 0; all slot valid bits cleared.
- Synchronous reset beats every other input, including scan_start in the same cycle.
- State machine: IDLE -> SCAN -> DONE -> IDLE.
  - scan_start in any state clears sprite_count, overflow and slot valids, and enters SCAN with the index at 0.
  - scan_start mid-scan therefore restarts the scan.
- SCAN issues oam_index = i on cycle i, for i = 0..SPRITE_COUNT-1. The entry for i is evaluated on cycle i+1.
  - After the last evaluation: DONE, scan_done = 1 for one cycle, then IDLE.
  - scan_done therefore occurs SPRITE_COUNT+1 cycles after scan_start.
  - scan_busy is high from the cycle after scan_start through the cycle before scan_done.
- Y match uses 9-bit arithmetic with no wrap:
  - match when line_y+16 >= y and line_y+16 < y+h, where h = 16 if tall else 8.
  - Consequently y = 0 never matches, and y >= 160 never matches.
- On a match:
  - if sprite_count < MAX_PER_LINE: store the entry in slot sprite_count, store r = line_y+16-y (4 bits), increment sprite_count;
  - otherwise set overflow and discard the entry.
- Stored row: r if attr bit 6 is clear, else h-1-r.
- Tile in tall mode: {tile[7:1], row[3]}, with hit_row = row[2:0]. Otherwise tile is unchanged and hit_row = row[2:0].
- Query: combinational match across all slots, output registered, latency 1 cycle.
  - A slot covers query_x when query_x+8 >= x and query_x+8 < x+8 (9-bit).
  - x = 0 and x >= 168 never hit.
  - col = query_x+8-x; if attr bit 5 is set, col = 7-col.
- Priority (DMG): smallest x wins; on equal x the lowest slot wins, which is the lowest OAM index.
- hit is forced to 0 while scan_busy or the DONE state is active.
- No opaque-pixel arbitration: a transparent winner is not replaced by a lower-priority sprite. That is the mixer's concern.
- Reset mid-scan: IDLE, no scan_done pulse, buffer empty.

Optional Feature:
- Macro PPU_CGB_PRIORITY_EN.
- Defined: priority is OAM index only, i.e. the lowest valid slot covering query_x wins regardless of x.
- Undefined: DMG x-then-index priority as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package ppu_pkg holds:
  - the oam_entry_t struct (y, x, tile, attr);
  - constants Y_OFFSET = 16, X_OFFSET = 8;
  - attribute bit positions ATTR_PAL = 4, ATTR_XFLIP = 5, ATTR_YFLIP = 6, ATTR_PRI = 7.
- Sub-module sprite_slot: one buffer entry with its X-cover comparator and column/flip computation, instantiated MAX_PER_LINE times.
- The priority reduction stays in the top module.

Test Plan:
- Single sprite: OAM0 = {y 16, x 8, tile 0x12, attr 0}, line_y = 0, then query_x = 3 -> sprite_count 1, hit 1, hit_tile 0x12, hit_row 0, hit_col 3; query_x = 8 -> hit 0.
- Overflow: OAM0..11 all y = 20, line_y = 4 -> scan_done at cycle 41, sprite_count 10, overflow 1; slots hold OAM0..9.
- Overlap: OAM2 x = 20 tile 0xA0, OAM5 x = 16 tile 0xB0, query_x = 13 -> DMG hit_tile 0xB0 with hit_col 5; with PPU_CGB_PRIORITY_EN hit_tile 0xA0 with hit_col 1.
- Tall plus flips: tall 1, sprite {y 16, x 8, tile 0x30, attr 0x60}, line_y 3, query_x 0 -> row 12, hit_tile 0x31, hit_row 4, hit_col 7.
- Boundaries: sprites y 0, y 160, x 0, x 168 -> never hit. Sprite y 159 on line_y 143 -> hit_row 0.
- Reset at cycle 10 of a scan -> scan_busy 0 next cycle, sprite_count 0, no scan_done. A new scan_start completes normally.
